// File: rtl/and_i8_share_arbiter.sv
// and_i8_share_arbiter: round-robin arbiter that time-shares one registered
// 8-bit AND unit between NUM_REQ requesters. The result returns on a tagged
// valid/ready response channel.
// Optional: define ARB_OP_COUNT_EN to add a saturating 16-bit op_count output.
module and_i8_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ID_W    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
`ifdef ARB_OP_COUNT_EN
  output logic [15:0]                op_count,
`endif
  output logic [WIDTH-1:0]           rsp_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_id;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [WIDTH-1:0]      r_y;
  logic                  w_any;
  logic [ID_W-1:0]       w_grant;
  logic [ID_W-1:0]       w_idx;
  logic [WIDTH-1:0]      w_a;
  logic [WIDTH-1:0]      w_b;
  logic                  w_accept;
  logic [NUM_REQ-1:0]    w_req_ready;

  // Round-robin search: first valid requester upward from rr_ptr+1, wrapping.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_a = req_a[32'(w_grant)*WIDTH +: WIDTH];
    w_b = req_b[32'(w_grant)*WIDTH +: WIDTH];
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state and request handshake; grant is accepted in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req_ready[w_grant] = 1'b1;
          w_accept             = 1'b1;
          w_state_nxt          = EXEC;
        end
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shared AND unit: input registers latched on accept, result registered in EXEC.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_id     <= '0;
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
    end else begin
      if (w_accept) begin
        r_a      <= w_a;
        r_b      <= w_b;
        r_id     <= w_grant;
        r_rr_ptr <= w_grant;
      end
      if (r_state == EXEC) r_y <= r_a & r_b;
    end
  end

`ifdef ARB_OP_COUNT_EN
  logic [15:0] r_op_count;

  // Saturating count of accepted responses.
  always_ff @(posedge clock) begin
    if (reset)                                          r_op_count <= '0;
    else if (rsp_valid && rsp_ready && r_op_count != '1) r_op_count <= r_op_count + 16'd1;
  end

  assign op_count = r_op_count;
`endif

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_y     = r_y;

endmodule

// File: tb/tb_and_i8_share_arbiter.sv
// Directed self-checking bench for and_i8_share_arbiter (NUM_REQ=4, WIDTH=8).
module tb_and_i8_share_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_y;
`ifdef ARB_OP_COUNT_EN
  logic [15:0] op_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  and_i8_share_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef ARB_OP_COUNT_EN
    .op_count  (op_count),
`endif
    .rsp_y     (rsp_y)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic do_reset;
    @(negedge clock);
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clock);
    reset     = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clock);
    #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_tests++; if (rsp_y !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_y: got %h want 00", rsp_y); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clock);
    req_valid = 4'b0001; req_a = {4{8'd3}}; req_b = {4{8'd3}}; rsp_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    @(negedge clock);
    req_valid = '0;
    #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_pulse: got %b want 0000", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec_valid: got %b want 0", rsp_valid); end
    @(negedge clock); #1;
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    n_tests++; if (rsp_y !== 8'd3) begin n_fail++; $display("FAIL single_rsp_y: got %h want 03", rsp_y); end
    n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id); end
    @(negedge clock); #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_mix;
    int cyc;
    req_a[23:16] = 8'hF0; req_b[23:16] = 8'h3C;
    req_valid = 4'b0100;
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mix_grant: got %b want 0100", req_ready); end
    @(negedge clock);
    req_valid = '0;
    #1;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 8) begin
      @(negedge clock); #1;
      cyc++;
    end
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mix_timeout: got rsp_valid %b want 1", rsp_valid); end
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL mix_latency: got %0d extra cycles want 1", cyc); end
    n_tests++; if (rsp_y !== 8'h30) begin n_fail++; $display("FAIL mix_rsp_y: got %h want 30", rsp_y); end
    n_tests++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL mix_rsp_id: got %0d want 2", rsp_id); end
    @(negedge clock);
  endtask

  task automatic test_rotation;
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic [7:0] ty [4];
    int         order [6];
    ta = '{8'hAA, 8'hF0, 8'h0F, 8'hFF};
    tb = '{8'hCC, 8'h3C, 8'h5A, 8'h81};
    ty = '{8'h88, 8'h30, 8'h0A, 8'h81};
    order = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = ta[i];
      req_b[i*8 +: 8] = tb[i];
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      #1;
      n_tests++; if (req_ready !== 4'(1 << order[g])) begin n_fail++; $display("FAIL rot_grant[%0d]: got %b want %b", g, req_ready, 4'(1 << order[g])); end
      @(negedge clock);
      @(negedge clock); #1;
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rot_valid[%0d]: got %b want 1", g, rsp_valid); end
      n_tests++; if (rsp_id !== 2'(order[g])) begin n_fail++; $display("FAIL rot_id[%0d]: got %0d want %0d", g, rsp_id, order[g]); end
      n_tests++; if (rsp_y !== ty[order[g]]) begin n_fail++; $display("FAIL rot_y[%0d]: got %h want %h", g, rsp_y, ty[order[g]]); end
      @(negedge clock);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    req_a[31:24] = 8'hC3; req_b[31:24] = 8'h7E;
    req_valid = 4'b1000; rsp_ready = 1'b0;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
    @(negedge clock);
    req_valid = 4'b0001;
    @(negedge clock);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", c, rsp_valid); end
      n_tests++; if (rsp_y !== 8'h42) begin n_fail++; $display("FAIL bp_y[%0d]: got %h want 42", c, rsp_y); end
      n_tests++; if (rsp_id !== 2'd3) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d want 3", c, rsp_id); end
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_final_valid: got %b want 1", rsp_valid); end
    @(negedge clock); #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_exec;
    do_reset();
    req_a[31:24] = 8'hC3; req_b[31:24] = 8'h7E;
    req_a[15:8]  = 8'h5A; req_b[15:8]  = 8'hF0;
    req_valid = 4'b1000; rsp_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rexec_grant3: got %b want 1000", req_ready); end
    @(negedge clock);
    reset = 1'b1; req_valid = '0;
    @(negedge clock);
    reset = 1'b0; req_valid = 4'b1010;
    #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rexec_valid: got %b want 0", rsp_valid); end
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rexec_grant1: got %b want 0010", req_ready); end
    n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rexec_id_clear: got %0d want 0", rsp_id); end
    n_tests++; if (rsp_y !== 8'h00) begin n_fail++; $display("FAIL rexec_y_clear: got %h want 00", rsp_y); end
    @(negedge clock);
    req_valid = '0;
    @(negedge clock); #1;
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rexec_rsp_valid: got %b want 1", rsp_valid); end
    n_tests++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL rexec_rsp_id: got %0d want 1", rsp_id); end
    n_tests++; if (rsp_y !== 8'h50) begin n_fail++; $display("FAIL rexec_rsp_y: got %h want 50", rsp_y); end
    @(negedge clock);
  endtask

`ifdef ARB_OP_COUNT_EN
  task automatic test_op_count;
    do_reset();
    #1;
    n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL cnt_reset: got %0d want 0", op_count); end
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0001;
      @(negedge clock); req_valid = '0;
      @(negedge clock);
      @(negedge clock);
    end
    #1;
    n_tests++; if (op_count !== 16'd3) begin n_fail++; $display("FAIL cnt_three: got %0d want 3", op_count); end
    rsp_ready = 1'b0; req_valid = 4'b0001;
    @(negedge clock); req_valid = '0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock); #1;
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL cnt_held_valid: got %b want 1", rsp_valid); end
    n_tests++; if (op_count !== 16'd3) begin n_fail++; $display("FAIL cnt_held: got %0d want 3", op_count); end
    rsp_ready = 1'b1;
    @(negedge clock); #1;
    n_tests++; if (op_count !== 16'd4) begin n_fail++; $display("FAIL cnt_accept: got %0d want 4", op_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_mix();
    test_rotation();
    test_backpressure();
    test_reset_exec();
`ifdef ARB_OP_COUNT_EN
    test_op_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
